dw_conv3x3_pe: RTL and testbench

Depthwise 3x3 convolution processing element for one channel. Sits directly downstream of the 3x3 line-buffer window generator and consumes its nine-pixel window stream over a valid/ready handshake. Holds nine signed fixed-point weights plus a bias, loaded over a serial config port. Emits one requantised, saturated output pixel per accepted window through a 3-stage stallable pipeline.

---
 rtl/dw_conv3x3_pe.sv | 179 +++++++++++++++++
 tb/tb_dw_conv3x3_pe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dw_conv3x3_pe.sv
// Depthwise 3x3 convolution PE for a single channel.
// Nine signed weights plus a bias are loaded serially. Each accepted window goes
// through a 3-stage stallable pipeline: multiply, then adder tree with bias, then
// round, saturate and register the output.
// Optional build macro DWCONV_RELU6_EN adds a ReLU6 clamp in stage 3.
// The clamp adds no latency.
module dw_conv3x3_pe #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  cfg_done,
  input  logic [DATA_WIDTH-1:0] w00,
  input  logic [DATA_WIDTH-1:0] w01,
  input  logic [DATA_WIDTH-1:0] w02,
  input  logic [DATA_WIDTH-1:0] w10,
  input  logic [DATA_WIDTH-1:0] w11,
  input  logic [DATA_WIDTH-1:0] w12,
  input  logic [DATA_WIDTH-1:0] w20,
  input  logic [DATA_WIDTH-1:0] w21,
  input  logic [DATA_WIDTH-1:0] w22,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] PixMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] PixMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMax =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`ifdef DWCONV_RELU6_EN
  localparam logic signed [DATA_WIDTH-1:0] Relu6Max = DATA_WIDTH'(6) << FRAC_BITS;
`endif

  typedef enum logic [1:0] {StUnloaded, StLoad, StRun, StDrain} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wgt_we, bias_we;
  logic signed [DATA_WIDTH-1:0] wgt_q [9];
  logic signed [DATA_WIDTH-1:0] bias_q;
  logic signed [DATA_WIDTH-1:0] win [9];

  logic advance, accept;
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic signed [PW-1:0] prod_d [9];
  logic signed [PW-1:0] s1_prod_q [9];
  logic signed [ACC_WIDTH-1:0] sum_d, s2_acc_q;
  logic signed [ACC_WIDTH-1:0] rnd, shr;
  logic signed [DATA_WIDTH-1:0] res_d, out_q;

  assign win = '{w00, w01, w02, w10, w11, w12, w20, w21, w22};

  // A stage moves forward only when the output slot is free or is being drained.
  assign advance   = ~s3_valid_q | out_ready;
  assign in_ready  = (state_q == StRun) & advance;
  assign accept    = in_valid & in_ready;
  assign busy      = s1_valid_q | s2_valid_q | s3_valid_q;
  assign cfg_done  = (state_q == StRun);
  assign out_valid = s3_valid_q;
  assign out_pixel = out_q;

  // Config sequencing: next state, word counter and register write strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wgt_we  = 1'b0;
    bias_we = 1'b0;
    case (state_q)
      StUnloaded: begin
        if (cfg_start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (cfg_start) begin
          cnt_d = '0;
        end else if (cfg_valid) begin
          if (cnt_q == 4'd9) begin
            bias_we = 1'b1;
            cnt_d   = '0;
            state_d = StRun;
          end else begin
            wgt_we = 1'b1;
            cnt_d  = cnt_q + 4'd1;
          end
        end
      end
      StRun: begin
        if (cfg_start) begin
          state_d = busy ? StDrain : StLoad;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        // Old weights stay in place until every in-flight window has left.
        if (!busy) state_d = StLoad;
      end
      default: state_d = StUnloaded;
    endcase
  end

  // FSM state and config counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StUnloaded;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Weight and bias storage written from the serial config port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) wgt_q[i] <= '0;
      bias_q <= '0;
    end else begin
      if (wgt_we)  wgt_q[cnt_q] <= cfg_data;
      if (bias_we) bias_q       <= cfg_data;
    end
  end

  // Stage 1 products and stage 2 adder tree with the bias aligned to the product scale.
  always_comb begin
    for (int i = 0; i < 9; i++) prod_d[i] = win[i] * wgt_q[i];
    sum_d = {{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
    sum_d = sum_d << FRAC_BITS;
    for (int i = 0; i < 9; i++) begin
      sum_d = sum_d + {{(ACC_WIDTH-PW){s1_prod_q[i][PW-1]}}, s1_prod_q[i]};
    end
  end

  // Stage 3 rounds half toward +inf, saturates, and optionally clamps to ReLU6.
  always_comb begin
    rnd = s2_acc_q + (ACC_WIDTH'(1) << (FRAC_BITS - 1));
    shr = rnd >>> FRAC_BITS;
    if (shr > AccMax)      res_d = PixMax;
    else if (shr < AccMin) res_d = PixMin;
    else                   res_d = shr[DATA_WIDTH-1:0];
`ifdef DWCONV_RELU6_EN
    if (res_d[DATA_WIDTH-1])    res_d = '0;
    else if (res_d > Relu6Max)  res_d = Relu6Max;
`endif
  end

  // Pipeline registers; all stages shift together or all hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) s1_prod_q[i] <= '0;
      s2_acc_q   <= '0;
      out_q      <= '0;
    end else if (advance) begin
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      for (int i = 0; i < 9; i++) s1_prod_q[i] <= prod_d[i];
      s2_acc_q   <= sum_d;
      out_q      <= res_d;
    end
  end

endmodule

// File: tb/tb_dw_conv3x3_pe.sv
// Directed testbench for dw_conv3x3_pe, with the default Q8.8 parameters.
module tb_dw_conv3x3_pe;

`ifdef DWCONV_RELU6_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, cfg_valid, cfg_done;
  logic [15:0] cfg_data;
  logic [15:0] win [9];
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] out_pixel;
  logic [15:0] cw [10];
  logic [15:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dw_conv3x3_pe dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_done(cfg_done),
    .w00(win[0]), .w01(win[1]), .w02(win[2]),
    .w10(win[3]), .w11(win[4]), .w12(win[5]),
    .w20(win[6]), .w21(win[7]), .w22(win[8]),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] sel(input logic [15:0] plain, input logic [15:0] relu6);
    return Relu ? relu6 : plain;
  endfunction

  task automatic set_win(input logic [15:0] v);
    for (int i = 0; i < 9; i++) win[i] = v;
  endtask

  task automatic set_wgts(input logic [15:0] w, input logic [15:0] b);
    for (int i = 0; i < 9; i++) cw[i] = w;
    cw[9] = b;
  endtask

  task automatic load_cfg();
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = cw[i];
      if (i == 9) check("cfg_done_early", cfg_done, 0);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    check("cfg_done", cfg_done, 1);
  endtask

  // Single window with no stall: the result must appear exactly three edges later.
  task automatic run_one(input string tag, input logic [15:0] expv);
    in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_pix"}, out_pixel, expv);
    @(negedge clk);
  endtask

  initial begin
    int k, got, c;
    logic stalled_prev;
    logic [15:0] prev_pix;

    rst = 1'b1;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    set_win(16'h0000);

    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("unloaded_in_ready", in_ready, 0);
    check("unloaded_busy", busy, 0);
    in_valid = 1'b0;

    // Unity weights, unity pixels.
    set_wgts(16'h0100, 16'h0000);
    load_cfg();
    set_win(16'h0100);
    run_one("ones", sel(16'h0900, 16'h0600));

    // Negative pixels with a half-unit bias.
    set_wgts(16'h0100, 16'h0080);
    load_cfg();
    set_win(16'hFF00);
    run_one("neg_bias", sel(16'hF780, 16'h0000));

    // Saturation at both rails.
    set_wgts(16'h7FFF, 16'h0000);
    load_cfg();
    set_win(16'h7FFF);
    run_one("sat_pos", sel(16'h7FFF, 16'h0600));
    set_win(16'h8000);
    run_one("sat_neg", sel(16'h8000, 16'h0000));

    // Rounding: only the centre tap is live, at half weight.
    set_wgts(16'h0000, 16'h0000);
    cw[4] = 16'h0080;
    load_cfg();
    set_win(16'h1234);
    win[4] = 16'h0001;
    run_one("round_up", 16'h0001);
    win[4] = 16'hFFFF;
    run_one("round_neg", 16'h0000);

    // Backpressure: eight windows streaming while out_ready is low during cycles 4..8.
    set_wgts(16'h0100, 16'h0000);
    load_cfg();
    k = 0; got = 0; c = 0;
    stalled_prev = 1'b0;
    prev_pix = '0;
    while (c < 60 && (k < 8 || exp_q.size() > 0)) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 8);
      if (k < 8) begin
        in_valid = 1'b1;
        set_win(16'(16 * (k + 1)));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_pix", out_pixel, prev_pix);
      end
      if (out_valid && !out_ready) check("bp_in_ready", in_ready, 0);
      stalled_prev = out_valid && !out_ready;
      prev_pix = out_pixel;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("bp_extra", out_valid, 0);
        else check("bp_pix", out_pixel, exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(16'(16'h0090 * (k + 1)));
        k++;
      end
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_count", got, 8);
    check("bp_left", exp_q.size(), 0);

    // Reconfigure with three windows in flight; they must finish on the old weights.
    @(negedge clk);
    set_win(16'h0010); in_valid = 1'b1;
    @(negedge clk);
    set_win(16'h0020);
    @(negedge clk);
    set_win(16'h0030);
    @(negedge clk);
    in_valid = 1'b0; cfg_start = 1'b1;
    #1;
    check("ms_a_valid", out_valid, 1);
    check("ms_a_pix", out_pixel, 16'h0090);
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    check("ms_in_ready", in_ready, 0);
    check("ms_cfg_done", cfg_done, 0);
    check("ms_b_valid", out_valid, 1);
    check("ms_b_pix", out_pixel, 16'h0120);
    @(negedge clk);
    check("ms_c_valid", out_valid, 1);
    check("ms_c_pix", out_pixel, 16'h01B0);
    check("ms_c_cfg_done", cfg_done, 0);
    @(negedge clk);
    check("ms_empty", out_valid, 0);
    check("ms_idle", busy, 0);
    set_wgts(16'h0200, 16'h0000);
    load_cfg();
    set_win(16'h0010);
    run_one("new_wgts", 16'h0120);

    // Asynchronous reset with two windows in the pipeline.
    @(negedge clk);
    set_win(16'h0010); in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_cfg_done", cfg_done, 0);
    check("arst_out_pixel", out_pixel, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 0);
    check("post_rst_out_valid", out_valid, 0);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
